// File: rtl/alu_pkg.sv
// Opcode encodings shared by the ALU, its reference model and the checker benches.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_NOT = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_SHR = 3'd7;

endpackage

// File: rtl/alu_ref_model.sv
// Purely combinational golden ALU: computes {exp_c, exp_y} from the applied vector.
module alu_ref_model
   import alu_pkg::*;
#(
   parameter int N_WIDTH = 4
) (
   input  logic [N_WIDTH-1:0] a,
   input  logic [N_WIDTH-1:0] b,
   input  logic               c_in,
   input  logic [2:0]         sel,
   output logic [N_WIDTH-1:0] exp_y,
   output logic               exp_c
);

   always_comb begin
      // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
      exp_y = '0;
      exp_c = 1'b0;
      case (sel)
         OP_ADD: {exp_c, exp_y} = {1'b0, a} + {1'b0, b} + (N_WIDTH + 1)'(c_in);
         OP_SUB: {exp_c, exp_y} = {1'b0, a} + {1'b0, ~b} + (N_WIDTH + 1)'(c_in);
         OP_AND: exp_y = a & b;
         OP_OR:  exp_y = a | b;
         OP_XOR: exp_y = a ^ b;
         OP_NOT: exp_y = ~a;
         OP_SHL: begin
            exp_y = {a[N_WIDTH-2:0], c_in};
            exp_c = a[N_WIDTH-1];
         end
         OP_SHR: begin
            exp_y = {c_in, a[N_WIDTH-1:1]};
            exp_c = a[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_response_checker.sv
// Two-stage ALU result checker: stage 1 registers vector/observed/expected, stage 2
// compares, counts, captures the first failure and flags end of sweep.
module alu_response_checker
   import alu_pkg::*;
#(
   parameter int N_WIDTH   = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   in_valid,
   input  logic                   in_last,
   input  logic [N_WIDTH-1:0]     a,
   input  logic [N_WIDTH-1:0]     b,
   input  logic                   c_in,
   input  logic [2:0]             sel,
   input  logic [N_WIDTH-1:0]     y,
   input  logic                   c_out,
   output logic                   mismatch,
   output logic [CNT_WIDTH-1:0]   sample_cnt,
   output logic [CNT_WIDTH-1:0]   err_cnt,
   output logic                   fail_valid,
   output logic [2*N_WIDTH+3:0]   fail_vec,
   output logic [N_WIDTH:0]       fail_got,
   output logic [N_WIDTH:0]       fail_exp,
   output logic                   done,
   output logic                   pass
);

   logic [N_WIDTH-1:0]   exp_y;
   logic                 exp_c;
   logic                 v1;
   logic                 last1;
   logic [2*N_WIDTH+3:0] vec1;
   logic [N_WIDTH:0]     got1;
   logic [N_WIDTH:0]     exp1;
   logic                 differs;

   alu_ref_model #(.N_WIDTH(N_WIDTH)) u_ref (
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .sel   (sel),
      .exp_y (exp_y),
      .exp_c (exp_c)
   );

   // Stage 1: capture the sample; clear drops anything presented alongside it.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         v1    <= 1'b0;
         last1 <= 1'b0;
         vec1  <= '0;
         got1  <= '0;
         exp1  <= '0;
      end else begin
         v1 <= in_valid && !clear;
         if (in_valid && !clear) begin
            last1 <= in_last;
            vec1  <= {a, b, c_in, sel};
            got1  <= {c_out, y};
            exp1  <= {exp_c, exp_y};
         end
      end
   end

   // Case inequality makes an X on the observed result count as a failure in simulation.
   assign differs = (got1 !== exp1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch   <= 1'b0;
         sample_cnt <= '0;
         err_cnt    <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
         fail_got   <= '0;
         fail_exp   <= '0;
         done       <= 1'b0;
      end else if (clear) begin
         mismatch   <= 1'b0;
         sample_cnt <= '0;
         err_cnt    <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
         fail_got   <= '0;
         fail_exp   <= '0;
         done       <= 1'b0;
      end else begin
         mismatch <= 1'b0;
         if (v1) begin
            sample_cnt <= sample_cnt + CNT_WIDTH'(1);
            if (differs) begin
               mismatch <= 1'b1;
               if (err_cnt != '1) err_cnt <= err_cnt + CNT_WIDTH'(1);
               if (!fail_valid) begin
                  fail_valid <= 1'b1;
                  fail_vec   <= vec1;
                  fail_got   <= got1;
                  fail_exp   <= exp1;
               end
            end
            if (last1) done <= 1'b1;
         end
      end
   end

   assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_alu_response_checker.sv
// Self-checking bench for alu_response_checker: directed table, corner sequences,
// randomized stream against an arithmetic reference, full sweep and counter saturation.
module tb_alu_response_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic [3:0]  a = '0, b = '0, y = '0;
   logic        c_in = 1'b0, c_out = 1'b0;
   logic [2:0]  sel = '0;

   logic        mismatch, fail_valid, done, pass;
   logic [15:0] sample_cnt, err_cnt;
   logic [11:0] fail_vec;
   logic [4:0]  fail_got, fail_exp;

   logic        s_mismatch, s_fail_valid, s_done, s_pass;
   logic [3:0]  s_sample_cnt, s_err_cnt;
   logic [11:0] s_fail_vec;
   logic [4:0]  s_fail_got, s_fail_exp;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   alu_response_checker #(.N_WIDTH(4), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_last(in_last),
      .a(a), .b(b), .c_in(c_in), .sel(sel), .y(y), .c_out(c_out),
      .mismatch(mismatch), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
      .fail_valid(fail_valid), .fail_vec(fail_vec), .fail_got(fail_got),
      .fail_exp(fail_exp), .done(done), .pass(pass)
   );

   alu_response_checker #(.N_WIDTH(4), .CNT_WIDTH(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_last(in_last),
      .a(a), .b(b), .c_in(c_in), .sel(sel), .y(y), .c_out(c_out),
      .mismatch(s_mismatch), .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt),
      .fail_valid(s_fail_valid), .fail_vec(s_fail_vec), .fail_got(s_fail_got),
      .fail_exp(s_fail_exp), .done(s_done), .pass(s_pass)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference result {c,y} from the opcode definitions using plain integer arithmetic.
   function automatic logic [4:0] ref_fn(input logic [3:0] fa, input logic [3:0] fb,
                                         input logic fc, input logic [2:0] fs);
      int ai, bi, ci, r;
      ai = int'(fa); bi = int'(fb); ci = int'(fc);
      case (fs)
         3'd0: r = ai + bi + ci;
         3'd1: r = ai + (15 - bi) + ci;
         3'd2: r = int'(fa & fb);
         3'd3: r = int'(fa | fb);
         3'd4: r = int'(fa ^ fb);
         3'd5: r = 15 - ai;
         3'd6: r = ((ai * 2 + ci) % 16) + (ai / 8) * 16;
         default: r = ci * 8 + ai / 2 + (ai % 2) * 16;
      endcase
      return r[4:0];
   endfunction

   task automatic drive(input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                        input logic [2:0] ts, input logic [4:0] tgot,
                        input logic tv, input logic tl);
      a = ta; b = tb_; c_in = tc; sel = ts;
      {c_out, y} = tgot;
      in_valid = tv; in_last = tl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1; in_valid = 1'b0;
      tick();
      clear = 1'b0;
   endtask

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [2:0] sel;
      logic [4:0] got;
      logic       is_bad;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int exp_samples, exp_errs;
      logic pend_v, pend_bad, cur_bad, want_mm;
      logic [3:0] ra, rb;
      logic rc;
      logic [2:0] rs;
      logic [4:0] e, g;
      int idx;

      tbl[0] = '{4'hF, 4'h1, 1'b1, 3'd0, 5'h11, 1'b0};  // ADD correct
      tbl[1] = '{4'h3, 4'h5, 1'b1, 3'd1, 5'h1E, 1'b1};  // SUB wrong carry
      tbl[2] = '{4'hC, 4'hA, 1'b0, 3'd2, 5'h08, 1'b0};  // AND
      tbl[3] = '{4'hC, 4'hA, 1'b1, 3'd3, 5'h0E, 1'b0};  // OR
      tbl[4] = '{4'hC, 4'hA, 1'b0, 3'd4, 5'h06, 1'b0};  // XOR
      tbl[5] = '{4'h5, 4'h0, 1'b0, 3'd5, 5'h0A, 1'b0};  // NOT
      tbl[6] = '{4'h9, 4'h0, 1'b0, 3'd6, 5'h12, 1'b0};  // SHL
      tbl[7] = '{4'h9, 4'h0, 1'b1, 3'd7, 5'h1C, 1'b0};  // SHR
      tbl[8] = '{4'h7, 4'h8, 1'b0, 3'd0, 5'h0E, 1'b1};  // ADD wrong y

      // Reset state
      #2;
      check("rst_sample_cnt", 32'(sample_cnt), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);
      check("rst_done", 32'(done), 0);
      check("rst_pass", 32'(pass), 0);
      check("rst_fail_valid", 32'(fail_valid), 0);
      @(negedge clk); rst_n = 1'b1;
      tick();

      // Reset mid-stream: three vectors in flight, reset between edges
      for (int i = 0; i < 3; i++) begin
         drive(4'(i), 4'h2, 1'b0, 3'd1, 5'h1E, 1'b1, 1'b1);
         tick();
      end
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("midrst_sample_cnt", 32'(sample_cnt), 0);
      check("midrst_err_cnt", 32'(err_cnt), 0);
      check("midrst_mismatch", 32'(mismatch), 0);
      check("midrst_fail_valid", 32'(fail_valid), 0);
      check("midrst_done", 32'(done), 0);
      @(negedge clk); rst_n = 1'b1;
      tick(); tick();
      check("postrst_sample_cnt", 32'(sample_cnt), 0);
      check("postrst_done", 32'(done), 0);

      // Directed table
      exp_samples = 0; exp_errs = 0;
      foreach (tbl[i]) begin
         drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sel, tbl[i].got, 1'b1, 1'b0);
         tick();
         in_valid = 1'b0;
         tick();
         exp_samples++;
         if (tbl[i].is_bad) exp_errs++;
         check($sformatf("tbl%0d_mismatch", i), 32'(mismatch), 32'(tbl[i].is_bad));
         check($sformatf("tbl%0d_sample_cnt", i), 32'(sample_cnt), 32'(exp_samples));
         check($sformatf("tbl%0d_err_cnt", i), 32'(err_cnt), 32'(exp_errs));
         if (i == 1) begin
            check("sub_fail_vec", 32'(fail_vec), 32'({4'h3, 4'h5, 1'b1, 3'd1}));
            check("sub_fail_got", 32'(fail_got), 32'h1E);
            check("sub_fail_exp", 32'(fail_exp), 32'h0E);
         end
         tick();
         check($sformatf("tbl%0d_pulse_end", i), 32'(mismatch), 0);
      end
      check("tbl_fail_vec_kept", 32'(fail_vec), 32'({4'h3, 4'h5, 1'b1, 3'd1}));
      check("tbl_done", 32'(done), 0);

      // First-failure retention: two failing SHR vectors back-to-back
      do_clear();
      check("clr_err_cnt", 32'(err_cnt), 0);
      check("clr_fail_valid", 32'(fail_valid), 0);
      drive(4'h6, 4'h0, 1'b0, 3'd7, 5'h00, 1'b1, 1'b0);
      tick();
      drive(4'h1, 4'h0, 1'b1, 3'd7, 5'h08, 1'b1, 1'b0);
      tick();
      in_valid = 1'b0;
      tick();
      check("ret_err_cnt", 32'(err_cnt), 2);
      check("ret_fail_vec", 32'(fail_vec), 32'({4'h6, 4'h0, 1'b0, 3'd7}));
      check("ret_fail_got", 32'(fail_got), 32'h00);
      check("ret_fail_exp", 32'(fail_exp), 32'h03);

      // Clear in the same cycle as a vector discards the vector
      do_clear();
      clear = 1'b1;
      drive(4'h1, 4'h1, 1'b0, 3'd0, 5'h1F, 1'b1, 1'b1);
      tick();
      clear = 1'b0; in_valid = 1'b0;
      tick();
      check("clrv_sample_cnt", 32'(sample_cnt), 0);
      check("clrv_err_cnt", 32'(err_cnt), 0);
      check("clrv_done", 32'(done), 0);

      // Randomized stream with gaps against the arithmetic reference
      exp_samples = 0; exp_errs = 0;
      pend_v = 1'b0; pend_bad = 1'b0;
      for (int i = 0; i <= 400; i++) begin
         ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom); rs = 3'($urandom);
         e = ref_fn(ra, rb, rc, rs);
         cur_bad = 1'b0;
         g = e;
         if (i < 400 && $urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 3) == 0) begin
               cur_bad = 1'b1;
               g = e ^ 5'($urandom_range(1, 31));
            end
            drive(ra, rb, rc, rs, g, 1'b1, 1'b0);
         end else begin
            drive(ra, rb, rc, rs, 5'($urandom), 1'b0, 1'b0);
         end
         tick();
         want_mm = 1'b0;
         if (pend_v) begin
            exp_samples++;
            if (pend_bad) begin
               exp_errs++;
               want_mm = 1'b1;
            end
         end
         pend_v = in_valid;
         pend_bad = cur_bad;
         check("rnd_mismatch", 32'(mismatch), 32'(want_mm));
         check("rnd_sample_cnt", 32'(sample_cnt), 32'(exp_samples));
         check("rnd_err_cnt", 32'(err_cnt), 32'(exp_errs));
      end
      in_valid = 1'b0;
      tick();

      // Full exhaustive sweep of correct results
      do_clear();
      idx = 0;
      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int is = 0; is < 8; is++)
               for (int ic = 0; ic < 2; ic++) begin
                  e = ref_fn(4'(ia), 4'(ib), 1'(ic), 3'(is));
                  drive(4'(ia), 4'(ib), 1'(ic), 3'(is), e, 1'b1, idx == 4095);
                  idx++;
                  tick();
               end
      in_valid = 1'b0; in_last = 1'b0;
      check("sweep_done_early", 32'(done), 0);
      tick();
      check("sweep_done", 32'(done), 1);
      check("sweep_pass", 32'(pass), 1);
      check("sweep_sample_cnt", 32'(sample_cnt), 4096);
      check("sweep_err_cnt", 32'(err_cnt), 0);
      do_clear();
      check("sweep_clr_done", 32'(done), 0);
      check("sweep_clr_pass", 32'(pass), 0);
      check("sweep_clr_sample_cnt", 32'(sample_cnt), 0);

      // Saturation with a 4-bit counter instance
      do_clear();
      for (int i = 0; i < 20; i++) begin
         e = ref_fn(4'(i), 4'h3, 1'b0, 3'd0);
         drive(4'(i), 4'h3, 1'b0, 3'd0, e ^ 5'h01, 1'b1, 1'b0);
         tick();
      end
      in_valid = 1'b0;
      tick();
      check("sat_err_cnt", 32'(s_err_cnt), 32'hF);
      check("sat_sample_cnt", 32'(s_sample_cnt), 4);
      check("sat_wide_err_cnt", 32'(err_cnt), 20);
      check("sat_fail_valid", 32'(s_fail_valid), 1);
      check("sat_pass", 32'(s_pass), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_response_checker.md
Name: alu_response_checker

Overview:
- Result-side counterpart to the ALU stimulus sweep: consumes each applied (a, b, c_in, sel) vector together with the ALU's y/c_out.
- Recomputes the golden result, compares registered results, counts samples and mismatches, and latches the first failing vector.
- Sits beside the alu in self-checking simulation and FPGA bring-up harnesses.
- Reports pass/fail at end of sweep.

Parameters:
- N_WIDTH, 4, operand/result width.
- CNT_WIDTH, 16, width of the sample and error counters.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of counters, done and capture registers.
- in_valid  input  1  current vector and ALU outputs are valid this cycle.
- in_last  input  1  qualifies in_valid; final vector of the sweep.
- a  input  N_WIDTH  operand A applied to the ALU.
- b  input  N_WIDTH  operand B applied to the ALU.
- c_in  input  1  carry in applied to the ALU.
- sel  input  3  opcode applied to the ALU.
- y  input  N_WIDTH  ALU result.
- c_out  input  1  ALU carry out.
- mismatch  output  1  one-cycle pulse, previous sample failed.
- sample_cnt  output  CNT_WIDTH  samples checked.
- err_cnt  output  CNT_WIDTH  mismatches, saturating.
- fail_valid  output  1  first-failure capture holds data.
- fail_vec  output  2*N_WIDTH+4  {a,b,c_in,sel} of first failure.
- fail_got  output  N_WIDTH+1  {c_out,y} observed at first failure.
- fail_exp  output  N_WIDTH+1  {c_out,y} expected at first failure.
- done  output  1  sweep finished, sticky.
- pass  output  1  done && err_cnt==0.

Behaviour:
- Reset (rst_n low, async): all outputs 0. The internal stage-1 valid is also cleared, so an in-flight sample is discarded.
- Golden model, combinational on inputs, with {exp_c,exp_y} of width N_WIDTH+1:
  - 0 ADD: a+b+c_in.
  - 1 SUB: a+~b+c_in; c_in=1 gives a-b, and c_out=1 means no borrow.
  - 2 AND: a&b, carry 0.
  - 3 OR: a|b, carry 0.
  - 4 XOR: a^b, carry 0.
  - 5 NOT: ~a, carry 0.
  - 6 SHL: y={a[N-2:0],c_in}, c_out=a[N-1].
  - 7 SHR: y={c_in,a[N-1:1]}, c_out=a[0].
- Stage 1 (edge where in_valid=1): register the vector, {c_out,y}, {exp_c,exp_y}, and in_last. Set v1=1; otherwise v1=0.
- Stage 2 (edge where v1=1): compare registered got vs exp.
  - sample_cnt increments, wrapping.
  - On inequality: mismatch=1 for one cycle and err_cnt increments, saturating at all-ones.
  - If fail_valid=0, load fail_vec/fail_got/fail_exp and set fail_valid; later failures do not overwrite.
  - If the registered last=1, set done.
- Latency: vector at edge k → mismatch/counters updated at edge k+1 → done visible after edge k+1.
- Back-to-back in_valid every cycle is supported, giving full throughput with no stall.
- After done=1, further in_valid samples are still checked and counted; done stays 1.
- clear has priority over stage-2 updates in the same cycle. It zeroes counters, done, and fail_*, and drops v1. A vector presented with in_valid in the same cycle is discarded.
- in_valid=0: no state change except v1 deasserting; y/c_out are ignored.
- X on y/c_out while v1=1 counts as a mismatch, since the comparison uses !==-equivalent semantics in sim; synthesis uses a plain compare.
- pass is combinational from registered done and err_cnt.

Decomposition:
- Package alu_pkg holds the opcode localparams OP_ADD..OP_SHR (3'd0..3'd7), shared with alu and its benches.
- One sub-module, alu_ref_model: purely combinational golden model (a, b, c_in, sel → exp_y, exp_c), reusable by the alu testbench.

Test Plan:
- Reset mid-stream: issue 3 vectors, pull rst_n low between edges → all outputs 0 immediately; the pending sample is not counted after release.
- Correct ADD: a=4'hF, b=4'h1, c_in=1, sel=0, y=4'h1, c_out=1 → mismatch stays 0, sample_cnt=1, err_cnt=0.
- Wrong SUB: a=4'h3, b=4'h5, c_in=1, sel=1, y=4'hE, c_out=1 (expected 4'hE, c_out=0) → mismatch pulse at the next edge, err_cnt=1, fail_vec={3,5,1,1}, fail_got=5'h1E, fail_exp=5'h0E.
- First-failure retention: two different failing SHR vectors back-to-back → err_cnt=2, fail_* hold the first vector only.
- Full sweep: feed 4096 correct vectors (16×16×8×2), last flagged in_last → done=1, pass=1, sample_cnt=4096; then assert clear → all zero next edge.
- Saturation: CNT_WIDTH=4, 20 consecutive failing vectors → err_cnt=4'hF, sample_cnt=4 (wrapped from 20).
